sync_xfer_arbiter: RTL and testbench
====================================

// Module: sync_xfer_arbiter
// PURPOSE
// - Source-domain (clk_a) round-robin arbiter sharing one two-flop level crossing among NUM_REQ requesters.
// - Runs a 4-phase level handshake on the crossing: sync_vld to the clk_b synchronizer,
//   sync_ack back from a clk_a synchronizer; bundled data is held stable on sync_data meanwhile.
// - Sits between local requesters and the vld/ack synchronizer pair of the CDC link.
// PARAMETERS
// - NUM_REQ     4     number of requesters, 2..16
// - DW          8     data width per requester
// - IDW         2     owner id width, >= clog2(NUM_REQ)
// - TO_CYCLES   64    watchdog limit per handshake phase, used only with CDC_ARB_TIMEOUT_EN
// PORTS
// - clk_a        in   1          source-domain clock
// - rst_n_a      in   1          async active-low reset
// - req          in   NUM_REQ    per-requester level request, held until its done pulse
// - req_data     in   NUM_REQ*DW packed data, slice i = req_data[i*DW +: DW]
// - done         out  NUM_REQ    one-cycle completion pulse to the owner
// - busy         out  1          high whenever state != IDLE
// - owner_id     out  IDW        index of current owner, valid while busy
// - sync_vld     out  1          level into crossing (vld_in of the synchronizer)
// - sync_data    out  DW         bundled data, stable from sync_vld rise until sync_ack falls
// - sync_ack     in   1          ack already synchronized into clk_a
// - timeout_err  out  1          one-cycle pulse on watchdog abort (0 without macro)
// BEHAVIOUR
// - Reset: state=IDLE, rr_ptr=0, done=0, busy=0, owner_id=0, sync_vld=0, sync_data=0, timeout_err=0.
// - States: IDLE -> ASSERT -> RELEASE -> IDLE. All outputs registered.
// - IDLE: if |req, pick first set bit scanning rr_ptr, rr_ptr+1, ... (mod NUM_REQ);
//   latch owner_id and sync_data=req_data[owner]; sync_vld<=1; go ASSERT. Idle 1 cycle min.
// - Latency: req sampled high at edge N -> sync_vld, busy high after edge N.
// - ASSERT: hold sync_vld=1; on sync_ack=1: sync_vld<=0, done[owner]<=1 (1 cycle), go RELEASE.
// - RELEASE: sync_vld=0, sync_data held; on sync_ack=0: rr_ptr<=owner_id+1 (wrap NUM_REQ-1 -> 0), go IDLE.
// - Next grant no earlier than the cycle after RELEASE exits; no back-to-back without ack low.
// - req changes after grant are ignored until IDLE; req_data changes after grant do not affect sync_data.
// - Requester must drop req within the cycle after done, else it is re-arbitrated (fairly, by rr_ptr).
// - Simultaneous requests: exactly one winner per handshake; every active requester served within NUM_REQ handshakes.
// - sync_ack high while IDLE (stale): no grant until sync_ack low.
// - Reset mid-transfer: immediate return to reset values; no done pulse for aborted transfer.
// CONFIGURATION
// - CDC_ARB_TIMEOUT_EN defined: 
//   phase counter cleared on each state entry, increments in ASSERT/RELEASE.
//   ASSERT reaching TO_CYCLES: sync_vld<=0, timeout_err pulse, no done, go RELEASE.
//   RELEASE reaching TO_CYCLES: timeout_err pulse, rr_ptr advances, go IDLE.
// - Undefined: no counter, timeout_err tied 0, handshake waits indefinitely.
// TESTING
// - Single req[1]=1, data 0xA5, ack rises 3 cycles after sync_vld, falls 3 later -> owner_id=1, sync_data=0xA5, done=4'b0010 one cycle, busy low after ack low.
// - req=4'b1111 held, rr_ptr=0 -> grant order 0,1,2,3,0; done pulses in that order.
// - req[3] only after owner 3 completes -> rr_ptr wraps to 0; next req=4'b1001 grants 0.
// - req_data changed while sync_vld=1 -> sync_data unchanged until back in IDLE.
// - rst_n_a low during ASSERT -> sync_vld=0, busy=0 same cycle, no done; after release, pending req re-granted from rr_ptr=0.
// - With CDC_ARB_TIMEOUT_EN, TO_CYCLES=16, ack never rises -> sync_vld low after 16 cycles, timeout_err one pulse, done stays 0.

Source files
------------

// File: rtl/sync_xfer_arbiter.sv
// Round-robin arbiter in clk_a that shares one 4-phase vld/ack level crossing among NUM_REQ requesters.
// Optional per-phase watchdog is compiled in when CDC_ARB_TIMEOUT_EN is defined.
module sync_xfer_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DW        = 8,
  parameter int IDW       = 2,
  parameter int TO_CYCLES = 64
) (
  input  logic                  clk_a,
  input  logic                  rst_n_a,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*DW-1:0] req_data,
  output logic [NUM_REQ-1:0]    done,
  output logic                  busy,
  output logic [IDW-1:0]        owner_id,
  output logic                  sync_vld,
  output logic [DW-1:0]         sync_data,
  input  logic                  sync_ack,
  output logic                  timeout_err,
  output logic [1:0]            dbg_state
);

  if (NUM_REQ < 2 || NUM_REQ > 16 || (2**IDW) < NUM_REQ || TO_CYCLES < 1) begin : g_param_check
    $error("sync_xfer_arbiter: illegal parameter set");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [IDW-1:0]       r_rr_ptr;
  logic [NUM_REQ-1:0]   r_done;
  logic                 r_busy;
  logic [IDW-1:0]       r_owner_id;
  logic                 r_sync_vld;
  logic [DW-1:0]        r_sync_data;

  logic [NUM_REQ-1:0]   w_rot;
  logic                 w_found;
  logic [IDW:0]         w_off;
  logic [IDW:0]         w_sum;
  logic [IDW-1:0]       w_pick;
  logic [DW-1:0]        w_pick_data;
  logic                 w_grant;
  logic                 w_to_hit;
  logic                 w_to_fire;
  logic [IDW-1:0]       w_rr_inc;

  logic                 w_vld_nxt;
  logic [NUM_REQ-1:0]   w_done_nxt;
  logic [IDW-1:0]       w_owner_nxt;
  logic [DW-1:0]        w_data_nxt;
  logic [IDW-1:0]       w_rr_nxt;
  logic                 w_busy_nxt;

  // Rotate requests so bit 0 is the requester at rr_ptr; lowest set bit wins.
  assign w_rot = NUM_REQ'({req, req} >> r_rr_ptr);

  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && w_rot[i]) begin
        w_found = 1'b1;
        w_off   = (IDW+1)'(i);
      end
    end
  end

  assign w_sum  = {1'b0, r_rr_ptr} + w_off;
  assign w_pick = (w_sum >= (IDW+1)'(NUM_REQ)) ? (w_sum[IDW-1:0] - IDW'(NUM_REQ))
                                               : w_sum[IDW-1:0];

  always_comb begin
    w_pick_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick == IDW'(i)) w_pick_data = req_data[i*DW +: DW];
    end
  end

  // A stale ack still high from the previous transfer blocks any new grant.
  assign w_grant  = (r_state == ST_IDLE) && w_found && !sync_ack;
  assign w_rr_inc = (r_owner_id == IDW'(NUM_REQ - 1)) ? '0 : r_owner_id + IDW'(1);

  // Handshake: sync_vld rises with sync_data stable, stays high until sync_ack is seen high,
  // then falls; the transfer ends only when sync_ack is seen low again (4-phase, level based).
  always_ff @(posedge clk_a or negedge rst_n_a) begin
    if (!rst_n_a) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_to_fire   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant) w_state_nxt = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (sync_ack) begin
          w_state_nxt = ST_RELEASE;
        end else if (w_to_hit) begin
          w_state_nxt = ST_RELEASE;
          w_to_fire   = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!sync_ack) begin
          w_state_nxt = ST_IDLE;
        end else if (w_to_hit) begin
          w_state_nxt = ST_IDLE;
          w_to_fire   = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_vld_nxt   = r_sync_vld;
    w_done_nxt  = '0;
    w_owner_nxt = r_owner_id;
    w_data_nxt  = r_sync_data;
    w_rr_nxt    = r_rr_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_grant) begin
          w_vld_nxt   = 1'b1;
          w_owner_nxt = w_pick;
          w_data_nxt  = w_pick_data;
        end
      end
      ST_ASSERT: begin
        if (sync_ack) begin
          w_vld_nxt = 1'b0;
          for (int i = 0; i < NUM_REQ; i++) begin
            w_done_nxt[i] = (r_owner_id == IDW'(i));
          end
        end else if (w_to_fire) begin
          w_vld_nxt = 1'b0;
        end
      end
      ST_RELEASE: begin
        w_vld_nxt = 1'b0;
        if (!sync_ack || w_to_fire) w_rr_nxt = w_rr_inc;
      end
      default: w_vld_nxt = 1'b0;
    endcase
  end

  assign w_busy_nxt = (w_state_nxt != ST_IDLE);

  always_ff @(posedge clk_a or negedge rst_n_a) begin
    if (!rst_n_a) begin
      r_rr_ptr    <= '0;
      r_done      <= '0;
      r_busy      <= 1'b0;
      r_owner_id  <= '0;
      r_sync_vld  <= 1'b0;
      r_sync_data <= '0;
    end else begin
      r_rr_ptr    <= w_rr_nxt;
      r_done      <= w_done_nxt;
      r_busy      <= w_busy_nxt;
      r_owner_id  <= w_owner_nxt;
      r_sync_vld  <= w_vld_nxt;
      r_sync_data <= w_data_nxt;
    end
  end

`ifdef CDC_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYCLES + 1);

  logic [CW-1:0] r_phase_cnt;
  logic          r_timeout_err;

  assign w_to_hit = (r_state != ST_IDLE) && (r_phase_cnt == CW'(TO_CYCLES - 1));

  // Counter restarts on every state change so each phase gets its own budget.
  always_ff @(posedge clk_a or negedge rst_n_a) begin
    if (!rst_n_a) begin
      r_phase_cnt   <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_to_fire;
      if (w_state_nxt != r_state)  r_phase_cnt <= '0;
      else if (r_state != ST_IDLE) r_phase_cnt <= r_phase_cnt + CW'(1);
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_to_hit    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign done      = r_done;
  assign busy      = r_busy;
  assign owner_id  = r_owner_id;
  assign sync_vld  = r_sync_vld;
  assign sync_data = r_sync_data;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_sync_xfer_arbiter.sv
// Bench for sync_xfer_arbiter: the bench plays the far side of the crossing and the requesters,
// predicting each grant from a round-robin reference model.
module tb_sync_xfer_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int DW        = 8;
  localparam int IDW       = 2;
  localparam int TO_CYCLES = 16;

  logic                  clk_a = 1'b0;
  logic                  rst_n_a = 1'b0;
  logic [NUM_REQ-1:0]    req = '0;
  logic [NUM_REQ*DW-1:0] req_data = '0;
  logic [NUM_REQ-1:0]    done;
  logic                  busy;
  logic [IDW-1:0]        owner_id;
  logic                  sync_vld;
  logic [DW-1:0]         sync_data;
  logic                  sync_ack = 1'b0;
  logic                  timeout_err;
  logic [1:0]            dbg_state;

  int checks = 0;
  int errors = 0;
  int m_rr   = 0;
  logic [IDW-1:0] exp_q[$];

  sync_xfer_arbiter #(
    .NUM_REQ(NUM_REQ), .DW(DW), .IDW(IDW), .TO_CYCLES(TO_CYCLES)
  ) dut (
    .clk_a(clk_a), .rst_n_a(rst_n_a), .req(req), .req_data(req_data),
    .done(done), .busy(busy), .owner_id(owner_id), .sync_vld(sync_vld),
    .sync_data(sync_data), .sync_ack(sync_ack), .timeout_err(timeout_err),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk_a = ~clk_a;

  initial begin
    #500000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "simulation time limit");
  end

  // reference model: first requester at or after rr (mod NUM_REQ)
  function automatic int model_pick(input logic [NUM_REQ-1:0] r, input int rr);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r[(rr + k) % NUM_REQ]) return (rr + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic rand_data();
    for (int i = 0; i < NUM_REQ; i++) req_data[i*DW +: DW] = DW'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk_a);
    rst_n_a  = 1'b0;
    req      = '0;
    sync_ack = 1'b0;
    repeat (2) @(negedge clk_a);
    rst_n_a = 1'b1;
    m_rr    = 0;
    exp_q.delete();
  endtask

  // One full handshake; caller has req/req_data driven, DUT idle, sync_ack low.
  task automatic xfer(input int rise_dly, input int fall_dly, input bit drop, output int obs_owner);
    int                 exp_own;
    logic [DW-1:0]      exp_data;
    logic [NUM_REQ-1:0] exp_done;
    exp_own  = model_pick(req, m_rr);
    exp_data = req_data[exp_own*DW +: DW];
    exp_done = '0;
    exp_done[exp_own] = 1'b1;
    exp_q.push_back(IDW'(exp_own));
    @(negedge clk_a);
    obs_owner = int'(owner_id);
    checks++; if (sync_vld !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL grant_vld_busy got vld=%0b busy=%0b exp 1 1", sync_vld, busy); end
    checks++; if (owner_id !== exp_q[0]) begin errors++; $display("FAIL grant_owner got %0d exp %0d", owner_id, exp_q[0]); end
    checks++; if (sync_data !== exp_data) begin errors++; $display("FAIL grant_data got %0h exp %0h", sync_data, exp_data); end
    checks++; if (done !== '0 || timeout_err !== 1'b0) begin errors++; $display("FAIL grant_quiet got done=%0b to=%0b exp 0 0", done, timeout_err); end
    void'(exp_q.pop_front());
    for (int c = 0; c < rise_dly; c++) begin
      rand_data();
      @(negedge clk_a);
      checks++; if (sync_vld !== 1'b1 || done !== '0 || sync_data !== exp_data) begin errors++; $display("FAIL assert_hold got vld=%0b done=%0b data=%0h exp 1 0 %0h", sync_vld, done, sync_data, exp_data); end
    end
    sync_ack = 1'b1;
    @(negedge clk_a);
    checks++; if (sync_vld !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ack_vld_drop got vld=%0b busy=%0b exp 0 1", sync_vld, busy); end
    checks++; if (done !== exp_done) begin errors++; $display("FAIL done_pulse got %0b exp %0b", done, exp_done); end
    checks++; if (sync_data !== exp_data) begin errors++; $display("FAIL release_data got %0h exp %0h", sync_data, exp_data); end
    if (drop) req[exp_own] = 1'b0;
    rand_data();
    for (int c = 0; c < fall_dly; c++) begin
      @(negedge clk_a);
      checks++; if (done !== '0 || sync_vld !== 1'b0 || busy !== 1'b1 || sync_data !== exp_data) begin errors++; $display("FAIL release_hold got done=%0b vld=%0b busy=%0b data=%0h exp 0 0 1 %0h", done, sync_vld, busy, sync_data, exp_data); end
      rand_data();
    end
    sync_ack = 1'b0;
    @(negedge clk_a);
    checks++; if (busy !== 1'b0 || done !== '0 || sync_vld !== 1'b0) begin errors++; $display("FAIL back_idle got busy=%0b done=%0b vld=%0b exp 0 0 0", busy, done, sync_vld); end
    checks++; if (sync_data !== exp_data) begin errors++; $display("FAIL idle_data got %0h exp %0h", sync_data, exp_data); end
    m_rr = (exp_own + 1) % NUM_REQ;
  endtask

  task automatic test_reset();
    rst_n_a = 1'b0;
    req     = 4'b1111;
    rand_data();
    @(negedge clk_a);
    checks++; if (done !== '0 || busy !== 1'b0 || sync_vld !== 1'b0) begin errors++; $display("FAIL reset_ctrl got done=%0b busy=%0b vld=%0b exp 0 0 0", done, busy, sync_vld); end
    checks++; if (owner_id !== '0 || sync_data !== '0 || timeout_err !== 1'b0) begin errors++; $display("FAIL reset_data got id=%0d data=%0h to=%0b exp 0 0 0", owner_id, sync_data, timeout_err); end
    req     = '0;
    rst_n_a = 1'b1;
    @(negedge clk_a);
    checks++; if (busy !== 1'b0 || sync_vld !== 1'b0) begin errors++; $display("FAIL idle_no_req got busy=%0b vld=%0b exp 0 0", busy, sync_vld); end
  endtask

  task automatic test_single();
    int own;
    do_reset();
    rand_data();
    req_data[1*DW +: DW] = 8'hA5;
    req = 4'b0010;
    xfer(3, 3, 1'b1, own);
    checks++; if (own !== 1) begin errors++; $display("FAIL single_owner got %0d exp 1", own); end
  endtask

  task automatic test_round_robin();
    int own;
    int seq[5] = '{0, 1, 2, 3, 0};
    do_reset();
    req = 4'b1111;
    rand_data();
    for (int k = 0; k < 5; k++) begin
      xfer(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0, own);
      checks++; if (own !== seq[k]) begin errors++; $display("FAIL rr_order_%0d got %0d exp %0d", k, own, seq[k]); end
    end
    req = '0;
  endtask

  task automatic test_wrap();
    int own;
    do_reset();
    req = 4'b1000;
    rand_data();
    xfer(1, 1, 1'b1, own);
    checks++; if (own !== 3) begin errors++; $display("FAIL wrap_first got %0d exp 3", own); end
    req = 4'b1001;
    xfer(2, 1, 1'b1, own);
    checks++; if (own !== 0) begin errors++; $display("FAIL wrap_second got %0d exp 0", own); end
    req = '0;
  endtask

  task automatic test_stale_ack();
    int own;
    sync_ack = 1'b1;
    req      = 4'b0100;
    rand_data();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_a);
      checks++; if (busy !== 1'b0 || sync_vld !== 1'b0) begin errors++; $display("FAIL stale_ack_grant got busy=%0b vld=%0b exp 0 0", busy, sync_vld); end
    end
    sync_ack = 1'b0;
    xfer(2, 2, 1'b1, own);
    req = '0;
  endtask

  task automatic test_reset_mid();
    int own;
    int exp_own;
    req = 4'b1100;
    rand_data();
    exp_own = model_pick(req, m_rr);
    @(negedge clk_a);
    checks++; if (sync_vld !== 1'b1 || owner_id !== IDW'(exp_own)) begin errors++; $display("FAIL pre_reset_grant got vld=%0b id=%0d exp 1 %0d", sync_vld, owner_id, exp_own); end
    @(negedge clk_a);
    rst_n_a = 1'b0;
    #1;
    checks++; if (sync_vld !== 1'b0 || busy !== 1'b0 || done !== '0) begin errors++; $display("FAIL mid_reset_ctrl got vld=%0b busy=%0b done=%0b exp 0 0 0", sync_vld, busy, done); end
    checks++; if (owner_id !== '0 || sync_data !== '0) begin errors++; $display("FAIL mid_reset_data got id=%0d data=%0h exp 0 0", owner_id, sync_data); end
    @(negedge clk_a);
    checks++; if (done !== '0) begin errors++; $display("FAIL mid_reset_done got %0b exp 0", done); end
    rst_n_a = 1'b1;
    m_rr    = 0;
    exp_q.delete();
    xfer(1, 1, 1'b1, own);
    checks++; if (own !== 2) begin errors++; $display("FAIL post_reset_owner got %0d exp 2", own); end
    req = '0;
  endtask

  task automatic test_random();
    int own;
    for (int n = 0; n < 40; n++) begin
      req = req | NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      rand_data();
      xfer(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), own);
    end
    req = '0;
    @(negedge clk_a);
  endtask

`ifdef CDC_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int exp_own;
    req = 4'b0001;
    rand_data();
    exp_own = model_pick(req, m_rr);
    @(negedge clk_a);
    checks++; if (sync_vld !== 1'b1) begin errors++; $display("FAIL to_grant got %0b exp 1", sync_vld); end
    for (int c = 1; c < TO_CYCLES; c++) begin
      @(negedge clk_a);
      checks++; if (sync_vld !== 1'b1 || timeout_err !== 1'b0) begin errors++; $display("FAIL to_wait got vld=%0b to=%0b exp 1 0", sync_vld, timeout_err); end
    end
    @(negedge clk_a);
    checks++; if (sync_vld !== 1'b0 || timeout_err !== 1'b1 || done !== '0) begin errors++; $display("FAIL to_fire got vld=%0b to=%0b done=%0b exp 0 1 0", sync_vld, timeout_err, done); end
    req = '0;
    @(negedge clk_a);
    checks++; if (timeout_err !== 1'b0 || busy !== 1'b0 || done !== '0) begin errors++; $display("FAIL to_after got to=%0b busy=%0b done=%0b exp 0 0 0", timeout_err, busy, done); end
    m_rr = (exp_own + 1) % NUM_REQ;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_stale_ack();
    test_reset_mid();
    test_random();
`ifdef CDC_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
